// File: rtl/unidade_controle.sv
// Stack-machine control unit: fetches 21-bit words over req/ack and sequences datapath strobes.
// Optional stack depth checking is compiled in with `define UC_STACK_CHECK_EN.
module unidade_controle #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ack,
  input  logic [20:0]       instr_data,
  output logic              push,
  output logic              pop,
  output logic              controle_pilha,
  output logic              load_temp1,
  output logic              load_temp2,
  output logic [15:0]       din_UC,
  output logic [4:0]        opcode,
  input  logic              data_uc,
  output logic              halted,
  output logic              err
);

  // state  | meaning
  // IDLE   | after reset, waiting for start
  // FETCH  | instr_req high, waiting for instr_ack
  // DECODE | dispatch on IR opcode
  // LOAD1  | load_temp1 strobe
  // POP1   | pop strobe after first operand
  // LOAD2  | load_temp2 strobe
  // POP2   | pop strobe after second operand
  // EXEC   | opcode presented to ULA, data_uc sampled for JZ
  // WRITE  | push strobe (immediate or ULA result)
  // HALT   | sticky stop, halted high
  // ERROR  | sticky stack fault, err high
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_LOAD1, S_POP1, S_LOAD2,
    S_POP2, S_EXEC, S_WRITE, S_HALT, S_ERROR
  } state_t;

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_PUSHI = 5'h01;
  localparam logic [4:0] OP_POP   = 5'h02;
  localparam logic [4:0] OP_JMP   = 5'h10;
  localparam logic [4:0] OP_JZ    = 5'h11;
  localparam logic [4:0] OP_HALT  = 5'h1F;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [20:0]       ir_q, ir_d;
  logic [15:0]       din_q, din_d;
  logic [4:0]        opc_q, opc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              push_q, push_d;
  logic              pop_q, pop_d;
  logic              cp_q, cp_d;
  logic              lt1_q, lt1_d;
  logic              lt2_q, lt2_d;
  logic              halted_q, halted_d;

  logic [4:0]  op;
  logic [15:0] imm;
  logic        is_alu;
  logic        is_jz;
  logic        stack_fault;
  logic        restart;

  assign op      = ir_q[20:16];
  assign imm     = ir_q[15:0];
  assign is_alu  = (op >= 5'h03) && (op <= 5'h0F);
  assign is_jz   = (op == OP_JZ);
  assign restart = start && ((state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERROR));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    din_d   = din_q;
    opc_d   = opc_q;

    case (state_q)
      S_IDLE, S_HALT, S_ERROR: begin
        if (restart) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        if (instr_ack) begin
          ir_d    = instr_data;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (stack_fault) begin
          state_d = S_ERROR;
        end else if (op == OP_NOP) begin
          state_d = S_FETCH;
        end else if (op == OP_PUSHI) begin
          din_d   = imm;
          state_d = S_WRITE;
        end else if (op == OP_POP) begin
          state_d = S_POP1;
        end else if (is_alu || is_jz) begin
          state_d = S_LOAD1;
        end else if (op == OP_JMP) begin
          pc_d    = imm[ADDR_W-1:0];
          state_d = S_FETCH;
        end else if (op == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_LOAD1: state_d = S_POP1;
      S_POP1: begin
        if (is_alu)     state_d = S_LOAD2;
        else if (is_jz) state_d = S_EXEC;
        else            state_d = S_FETCH;
      end
      S_LOAD2: state_d = S_POP2;
      S_POP2:  state_d = S_EXEC;
      S_EXEC: begin
        if (is_jz) begin
          if (data_uc) pc_d = imm[ADDR_W-1:0];
          state_d = S_FETCH;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase

    // ULA opcode is latched on entry to EXEC and held until the next operation.
    if (state_d == S_EXEC) opc_d = op;

    // Outputs are registered versions of the next state so each strobe lines up with its state.
    req_d    = (state_d == S_FETCH);
    addr_d   = pc_d;
    push_d   = (state_d == S_WRITE);
    pop_d    = (state_d == S_POP1) || (state_d == S_POP2);
    lt1_d    = (state_d == S_LOAD1);
    lt2_d    = (state_d == S_LOAD2);
    cp_d     = (state_d == S_WRITE) && is_alu;
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      din_q    <= '0;
      opc_q    <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      cp_q     <= 1'b0;
      lt1_q    <= 1'b0;
      lt2_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      din_q    <= din_d;
      opc_q    <= opc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      push_q   <= push_d;
      pop_q    <= pop_d;
      cp_q     <= cp_d;
      lt1_q    <= lt1_d;
      lt2_q    <= lt2_d;
      halted_q <= halted_d;
    end
  end

`ifdef UC_STACK_CHECK_EN
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic [SP_W-1:0] sp_q, sp_d;
  logic            err_q, err_d;

  always_comb begin
    stack_fault = 1'b0;
    if (op == OP_PUSHI)                stack_fault = (sp_q == SP_W'(STACK_DEPTH));
    else if (op == OP_POP || is_jz)    stack_fault = (sp_q == '0);
    else if (is_alu)                   stack_fault = (sp_q < SP_W'(2));
  end

  // push and pop strobes are never active in the same cycle.
  always_comb begin
    sp_d = sp_q + SP_W'(push_q) - SP_W'(pop_q);
    if (restart) sp_d = '0;
  end

  assign err_d = (state_d == S_ERROR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_cfg;

  assign stack_fault = 1'b0;
  assign unused_cfg  = ^STACK_DEPTH;
  assign err         = 1'b0;
`endif

  assign instr_req      = req_q;
  assign instr_addr     = addr_q;
  assign push           = push_q;
  assign pop            = pop_q;
  assign controle_pilha = cp_q;
  assign load_temp1     = lt1_q;
  assign load_temp2     = lt2_q;
  assign din_UC         = din_q;
  assign opcode         = opc_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: an instruction-level model expands each program
// into the expected per-cycle outputs, checked every cycle against the DUT.
module tb_unidade_controle;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        instr_req;
  logic [7:0]  instr_addr;
  logic        instr_ack = 1'b0;
  logic [20:0] instr_data = '0;
  logic        push;
  logic        pop;
  logic        controle_pilha;
  logic        load_temp1;
  logic        load_temp2;
  logic [15:0] din_UC;
  logic [4:0]  opcode;
  logic        data_uc = 1'b0;
  logic        halted;
  logic        err;

  unidade_controle #(.ADDR_W(8), .STACK_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack), .instr_data(instr_data),
    .push(push), .pop(pop), .controle_pilha(controle_pilha),
    .load_temp1(load_temp1), .load_temp2(load_temp2),
    .din_UC(din_UC), .opcode(opcode), .data_uc(data_uc),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [7:0]  addr;
    logic        push;
    logic        pop;
    logic        lt1;
    logic        lt2;
    logic        cp;
    logic [15:0] din;
    logic [4:0]  opc;
    logic        halted;
    logic        err;
  } rec_t;

  int total = 0;
  int bad   = 0;

  logic [20:0] mem [256];
  int          wt  [256];
  bit          uc_q [$];
  bit          m_uc_q [$];
  rec_t        exp_q [$];
  rec_t        cur;
  bit          chk_en = 1'b0;
  int          cyc_i = 0;

  logic [7:0]  m_pc;
  logic [15:0] m_din = '0;
  logic [4:0]  m_opc = '0;
  logic        m_halt;
  logic        m_err;

  rec_t dut_vec;
  assign dut_vec = {instr_req, instr_addr, push, pop, load_temp1, load_temp2,
                    controle_pilha, din_UC, opcode, halted, err};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  function automatic logic [20:0] ins(input logic [4:0] op, input logic [15:0] imm);
    return {op, imm};
  endfunction

  // Instruction memory: acks after wt[addr] wait cycles; JZ fetches set data_uc from uc_q.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (instr_req) begin
        if (wcnt >= wt[instr_addr]) begin
          instr_ack  = 1'b1;
          instr_data = mem[instr_addr];
          if (mem[instr_addr][20:16] == 5'h11)
            data_uc = (uc_q.size() > 0) ? uc_q.pop_front() : 1'b0;
          wcnt = 0;
        end else begin
          instr_ack  = 1'b0;
          instr_data = 21'h1ABCDE;
          wcnt++;
        end
      end else begin
        instr_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Single compare process: one expected record per cycle after start.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk($sformatf("cycle%0d", cyc_i), dut_vec, cur);
        cyc_i++;
      end
    end
  end

  task automatic add(input logic req, input logic pu, input logic po,
                     input logic l1, input logic l2, input logic cp);
    rec_t r;
    r.req = req; r.addr = m_pc; r.push = pu; r.pop = po; r.lt1 = l1; r.lt2 = l2; r.cp = cp;
    r.din = m_din; r.opc = m_opc; r.halted = m_halt; r.err = m_err;
    exp_q.push_back(r);
  endtask

  function automatic bit stack_bad(input logic [4:0] op, input int sp);
`ifdef UC_STACK_CHECK_EN
    if (op == 5'h01) return sp >= 16;
    if (op == 5'h02 || op == 5'h11) return sp < 1;
    if (op >= 5'h03 && op <= 5'h0F) return sp < 2;
    return 1'b0;
`else
    return (op == 5'h1E) && (sp < -1000);
`endif
  endfunction

  // Interpret the program from PC 0; each instruction contributes its cycles:
  // fetch (1 + waits), decode, then the datapath steps the opcode needs.
  task automatic build_trace();
    int sp, steps;
    bit done, taken;
    logic [20:0] w;
    logic [4:0]  op;
    logic [15:0] imm;
    exp_q.delete();
    m_pc = '0; m_halt = 1'b0; m_err = 1'b0;
    sp = 0; done = 1'b0; steps = 0;
    while (!done && steps < 200) begin
      steps++;
      for (int k = 0; k <= wt[m_pc]; k++) add(1, 0, 0, 0, 0, 0);
      w = mem[m_pc]; op = w[20:16]; imm = w[15:0];
      m_pc = m_pc + 8'd1;
      add(0, 0, 0, 0, 0, 0);
      if (stack_bad(op, sp)) begin
        m_err = 1'b1; done = 1'b1;
      end else if (op == 5'h01) begin
        m_din = imm; add(0, 1, 0, 0, 0, 0); sp++;
      end else if (op == 5'h02) begin
        add(0, 0, 1, 0, 0, 0); sp--;
      end else if (op >= 5'h03 && op <= 5'h0F) begin
        add(0, 0, 0, 1, 0, 0); add(0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0); add(0, 0, 1, 0, 0, 0);
        m_opc = op; add(0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1); sp--;
      end else if (op == 5'h10) begin
        m_pc = imm[7:0];
      end else if (op == 5'h11) begin
        add(0, 0, 0, 1, 0, 0); add(0, 0, 1, 0, 0, 0);
        m_opc = op; add(0, 0, 0, 0, 0, 0);
        taken = (m_uc_q.size() > 0) ? m_uc_q.pop_front() : 1'b0;
        if (taken) m_pc = imm[7:0];
        sp--;
      end else if (op == 5'h1F) begin
        m_halt = 1'b1; done = 1'b1;
      end
    end
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i] = ins(5'h00, 16'h0000);
      wt[i]  = 0;
    end
    uc_q.delete();
    m_uc_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_prog(input int glitch_at);
    int n;
    pulse_start();
    cyc_i = 0;
    chk_en = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == glitch_at);
    end
    start = 1'b0;
    chk("drain", exp_q.size(), 0);
    chk_en = 1'b0;
  endtask

  function automatic int count_fetch(input logic [7:0] a);
    int c;
    c = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].req && exp_q[i].addr == a && (i == 0 || !exp_q[i-1].req || exp_q[i-1].addr != a))
        c++;
    end
    return c;
  endfunction

  initial begin
    int k, n, np;
    clear_mem();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", dut_vec, '0);
    chk("reset_req", instr_req, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_no_start", dut_vec, '0);

    // T1: PUSHI 5, PUSHI 3, ADD, HALT
    clear_mem();
    mem[0] = ins(5'h01, 16'h0005);
    mem[1] = ins(5'h01, 16'h0003);
    mem[2] = ins(5'h03, 16'h0000);
    mem[3] = ins(5'h1F, 16'h0000);
    build_trace();
    k = 0;
    while (k < exp_q.size() && !exp_q[k].halted) k++;
    chk("t1_pin_halt_cycle", k, 16);
    np = 0;
    for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].push) np++;
    chk("t1_pin_pushes", np, 3);
    chk("t1_pin_first_push", {exp_q[2].push, exp_q[2].din}, {1'b1, 16'h0005});
    run_prog(0);
    chk("t1_halted", halted, 1'b1);
    chk("t1_opcode", opcode, 5'h03);

    // T2: JMP 0x20 with 3 wait cycles
    clear_mem();
    mem[0]     = ins(5'h10, 16'h0020);
    wt[0]      = 3;
    mem[8'h20] = ins(5'h1F, 16'h0000);
    build_trace();
    k = 0;
    while (k < exp_q.size() && exp_q[k].req && exp_q[k].addr == 8'h00) k++;
    chk("t2_pin_wait", k, 4);
    chk("t2_pin_next", {exp_q[5].req, exp_q[5].addr}, {1'b1, 8'h20});
    run_prog(0);

    // T3: JZ taken then not taken
    clear_mem();
    mem[0]     = ins(5'h01, 16'h0007);
    mem[1]     = ins(5'h01, 16'h0007);
    mem[2]     = ins(5'h11, 16'h0040);
    mem[8'h40] = ins(5'h11, 16'h0050);
    mem[8'h41] = ins(5'h1F, 16'h0000);
    uc_q   = {1'b1, 1'b0};
    m_uc_q = {1'b1, 1'b0};
    build_trace();
    chk("t3_pin_targets",
        {count_fetch(8'h03), count_fetch(8'h40), count_fetch(8'h41), count_fetch(8'h50)},
        {32'd0, 32'd1, 32'd1, 32'd0});
    run_prog(0);
    chk("t3_opcode_held", opcode, 5'h11);

    // T4: reset asserted during LOAD2
    clear_mem();
    mem[0] = ins(5'h01, 16'h0001);
    mem[1] = ins(5'h01, 16'h0002);
    mem[2] = ins(5'h04, 16'h0000);
    build_trace();
    pulse_start();
    cyc_i = 0;
    chk_en = 1'b1;
    n = 0;
    while (!load_temp2 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t4_reach_load2", load_temp2, 1'b1);
    chk_en = 1'b0;
    exp_q.delete();
    chk("t4_din_before", din_UC, 16'h0002);
    reset = 1'b0;
    #1;
    chk("t4_async_all", dut_vec, '0);
    chk("t4_async_din", din_UC, 16'h0000);
    chk("t4_async_opc", opcode, 5'h00);
    m_din = '0;
    m_opc = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_mem();
    mem[0] = ins(5'h01, 16'h0005);
    mem[1] = ins(5'h01, 16'h0003);
    mem[2] = ins(5'h03, 16'h0000);
    mem[3] = ins(5'h1F, 16'h0000);
    build_trace();
    chk("t4_pin_addr0", {exp_q[0].req, exp_q[0].addr}, {1'b1, 8'h00});
    run_prog(0);

    // T5: ALU with a single stack entry
    clear_mem();
    mem[0] = ins(5'h01, 16'h0009);
    mem[1] = ins(5'h05, 16'h0000);
    mem[2] = ins(5'h1F, 16'h0000);
    build_trace();
    np = 0;
    for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].pop || exp_q[i].cp) np++;
`ifdef UC_STACK_CHECK_EN
    chk("t5_pin_no_strobes", np, 0);
    run_prog(0);
    chk("t5_err", {err, halted}, 2'b10);
`else
    chk("t5_pin_strobes", np, 3);
    run_prog(0);
    chk("t5_err", {err, halted}, 2'b01);
`endif

    // T6: NOP at 0xFF wraps to 0; start also clears a sticky ERROR
    clear_mem();
    mem[0]     = ins(5'h01, 16'h0001);
    mem[1]     = ins(5'h11, 16'h00FF);
    mem[2]     = ins(5'h1F, 16'h0000);
    mem[8'hFF] = ins(5'h00, 16'h0000);
    uc_q   = {1'b1, 1'b0};
    m_uc_q = {1'b1, 1'b0};
    build_trace();
    chk("t6_pin_wrap", {count_fetch(8'hFF), count_fetch(8'h00)}, {32'd1, 32'd2});
    run_prog(0);
    chk("t6_err_cleared", err, 1'b0);

    // T7: undefined opcode as NOP, start mid-run ignored
    clear_mem();
    mem[0] = ins(5'h01, 16'hABCD);
    wt[0]  = 2;
    mem[1] = ins(5'h12, 16'h1234);
    mem[2] = ins(5'h1F, 16'h0000);
    build_trace();
    chk("t7_pin_len", exp_q.size(), 3 + 2 + 2 + 2 + 4);
    run_prog(2);
    chk("t7_din", din_UC, 16'hABCD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
